// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounced multi-button press queue with round-robin valid/ready event output
module btn_event_arbiter #(
  parameter int N = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ID_W = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    raw,
  input  logic            evt_ready,
  input  logic            clr_overflow,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state;
  logic [N-1:0] s1, s2, stable, acc, rise, grant;
  logic [CW-1:0] cnt [N];
  logic [ID_W-1:0] ptr, gidx;
  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) acc[i] = (s2[i] ^ stable[i]) & (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end
  assign rise = acc & s2;
  // lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit below ptr
  always_comb begin
    gidx = '0;
    for (int j = N - 1; j >= 0; j--) if (pending[j] && ID_W'(j) < ptr) gidx = ID_W'(j);
    for (int j = N - 1; j >= 0; j--) if (pending[j] && ID_W'(j) >= ptr) gidx = ID_W'(j);
  end
  assign grant = (state == IDLE && |pending) ? N'(1) << gidx : '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      pending <= '0;
      overflow <= '0;
      ptr <= '0;
      evt_valid <= 1'b0;
      evt_id <= '0;
      state <= IDLE;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stable <= stable ^ acc;
      for (int i = 0; i < N; i++) cnt[i] <= (s2[i] == stable[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
      // a press landing on its own grant edge re-arms pending instead of overflowing
      pending <= (pending & ~grant) | rise;
      overflow <= (clr_overflow ? '0 : overflow) | (rise & pending & ~grant);
      if (state == IDLE) begin
        if (|pending) begin
          evt_id <= gidx;
          evt_valid <= 1'b1;
          state <= PRESENT;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
        state <= IDLE;
        ptr <= (evt_id == ID_W'(N - 1)) ? '0 : evt_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: table-driven and directed checks for btn_event_arbiter
module tb_btn_event_arbiter;
  logic clock = 0, reset = 0, evt_ready = 0, clr_overflow = 0;
  logic [3:0] raw = '0;
  logic evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending, overflow;
  int total = 0, bad = 0;

  btn_event_arbiter #(.N(4), .DEBOUNCE_CYCLES(4), .ID_W(2)) dut (
    .clock(clock), .reset(reset), .raw(raw), .evt_ready(evt_ready), .clr_overflow(clr_overflow),
    .evt_valid(evt_valid), .evt_id(evt_id), .pending(pending), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic       ready;
    logic       v;
    logic [1:0] id;
    logic [3:0] p;
    logic [3:0] o;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic rs, logic [3:0] r, logic rd, logic v, logic [1:0] id, logic [3:0] p);
    vec_t e;
    e.rst = rs; e.raw = r; e.ready = rd; e.v = v; e.id = id; e.p = p; e.o = 4'b0000;
    tbl.push_back(e);
  endfunction

  function automatic void rep(int n, logic [3:0] r, logic v, logic [1:0] id, logic [3:0] p);
    for (int k = 0; k < n; k++) add(1'b0, r, 1'b1, v, id, p);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 0;
    step();
    reset = 1;
  endtask

  task automatic pulse(input int ch);
    raw[ch] = 1'b1;
    repeat (6) step();
    raw[ch] = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    // reset state
    #12;
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_pend", pending, 0);
    check("rst_ovf", overflow, 0);
    reset = 1;

    // latency: pending after edge 5, valid after edge 6, accepted at edge 7
    raw = 4'b0100;
    evt_ready = 1;
    repeat (5) step();
    check("lat_pend_e4", pending, 4'b0000);
    step();
    check("lat_pend_e5", pending, 4'b0100);
    check("lat_valid_e5", evt_valid, 0);
    step();
    check("lat_present", {evt_valid, evt_id, pending}, {1'b1, 2'd2, 4'b0000});
    step();
    check("lat_accept", evt_valid, 0);
    raw = 0;
    repeat (6) step();

    // table: glitch reject, 4-cycle accept, round-robin 1111 then 1001
    add(1'b1, 4'b0000, 1'b1, 0, 0, 4'b0000);
    rep(3, 4'b0001, 0, 0, 4'b0000);
    rep(6, 4'b0000, 0, 0, 4'b0000);
    rep(4, 4'b0001, 0, 0, 4'b0000);
    rep(1, 4'b0000, 0, 0, 4'b0000);
    rep(1, 4'b0000, 0, 0, 4'b0001);
    rep(1, 4'b0000, 1, 0, 4'b0000);
    rep(2, 4'b0000, 0, 0, 4'b0000);
    add(1'b1, 4'b0000, 1'b1, 0, 0, 4'b0000);
    rep(5, 4'b1111, 0, 0, 4'b0000);
    rep(1, 4'b1111, 0, 0, 4'b1111);
    rep(1, 4'b1111, 1, 0, 4'b1110);
    rep(1, 4'b1111, 0, 0, 4'b1110);
    rep(1, 4'b1111, 1, 1, 4'b1100);
    rep(1, 4'b1111, 0, 1, 4'b1100);
    rep(1, 4'b1111, 1, 2, 4'b1000);
    rep(1, 4'b1111, 0, 2, 4'b1000);
    rep(1, 4'b1111, 1, 3, 4'b0000);
    rep(1, 4'b1111, 0, 3, 4'b0000);
    rep(6, 4'b0000, 0, 3, 4'b0000);
    rep(5, 4'b1001, 0, 3, 4'b0000);
    rep(1, 4'b1001, 0, 3, 4'b1001);
    rep(1, 4'b1001, 1, 0, 4'b1000);
    rep(1, 4'b1001, 0, 0, 4'b1000);
    rep(1, 4'b1001, 1, 3, 4'b0000);
    rep(1, 4'b1001, 0, 3, 4'b0000);
    foreach (tbl[i]) begin
      raw = tbl[i].raw;
      evt_ready = tbl[i].ready;
      if (tbl[i].rst) reset = 0;
      step();
      check($sformatf("vec%0d", i), {evt_valid, evt_id, pending, overflow},
            {tbl[i].v, tbl[i].id, tbl[i].p, tbl[i].o});
      reset = 1;
    end
    raw = 0;

    // backpressure and overflow on channel 1
    evt_ready = 0;
    do_reset();
    pulse(1);
    check("bp_present", {evt_valid, evt_id, pending, overflow}, {1'b1, 2'd1, 4'b0000, 4'b0000});
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("bp_hold%0d", k), {evt_valid, evt_id}, {1'b1, 2'd1});
    end
    pulse(1);
    check("bp_second", {evt_valid, evt_id, pending, overflow}, {1'b1, 2'd1, 4'b0010, 4'b0000});
    pulse(1);
    check("bp_third", {pending, overflow}, {4'b0010, 4'b0010});
    clr_overflow = 1;
    step();
    clr_overflow = 0;
    check("bp_clr", {evt_valid, evt_id, pending, overflow}, {1'b1, 2'd1, 4'b0010, 4'b0000});
    evt_ready = 1;
    step();
    check("bp_accept", {evt_valid, pending}, {1'b0, 4'b0010});
    step();
    check("bp_regrant", {evt_valid, evt_id, pending}, {1'b1, 2'd1, 4'b0000});
    step();
    check("bp_done", evt_valid, 0);

    // async reset mid-PRESENT, then pointer restarts at 0
    evt_ready = 0;
    pulse(2);
    pulse(2);
    pulse(2);
    check("ar_pre", {evt_valid, evt_id, pending, overflow}, {1'b1, 2'd2, 4'b0100, 4'b0100});
    #3 reset = 0;
    #1;
    check("ar_async", {evt_valid, pending, overflow}, {1'b0, 4'b0000, 4'b0000});
    #2 reset = 1;
    raw = 4'b1001;
    evt_ready = 1;
    repeat (7) step();
    check("ar_first", {evt_valid, evt_id, pending}, {1'b1, 2'd0, 4'b1000});
    step();
    check("ar_acc", evt_valid, 0);
    step();
    check("ar_second", {evt_valid, evt_id, pending}, {1'b1, 2'd3, 4'b0000});
    raw = 0;
    repeat (6) step();

    // grant/press collision on channel 3
    evt_ready = 0;
    do_reset();
    raw = 4'b1001;
    repeat (6) step();
    raw = 0;
    repeat (6) step();
    check("col_hold0", {evt_valid, evt_id, pending}, {1'b1, 2'd0, 4'b1000});
    raw = 4'b1000;
    repeat (4) step();
    evt_ready = 1;
    step();
    check("col_idle", {evt_valid, pending}, {1'b0, 4'b1000});
    evt_ready = 0;
    step();
    check("col_grant", {evt_valid, evt_id, pending, overflow}, {1'b1, 2'd3, 4'b1000, 4'b0000});
    evt_ready = 1;
    step();
    check("col_acc", evt_valid, 0);
    step();
    check("col_again", {evt_valid, evt_id, pending, overflow}, {1'b1, 2'd3, 4'b0000, 4'b0000});
    step();
    check("col_done", evt_valid, 0);
    raw = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Multi-button front end: N raw button inputs, each synchronised, debounced and rising-edge detected.
- Detected presses are queued as one pending flag per channel.
- Pending presses are shared onto a single event channel by a round-robin arbiter with a valid/ready handshake.
- Sits between board push-buttons and the control FSMs that consume one command at a time.

Parameters:
N, 4, number of button channels (2..16)
DEBOUNCE_CYCLES, 4, consecutive clocks a synchronised level must differ from the stable level before it is accepted (>=1)
ID_W, 2, width of evt_id; must be >= clog2(N)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset: 0 clears all state immediately, independent of clock
raw  input  N  raw button levels, asynchronous to clock
evt_ready  input  1  consumer accepts the presented event
clr_overflow  input  1  synchronous clear of all overflow flags
evt_valid  output  1  event presented
evt_id  output  ID_W  channel index of the presented event
pending  output  N  per-channel press-waiting flags
overflow  output  N  sticky flag: press lost because the channel was already pending

Behaviour:
- Reset (reset=0, async): all registers 0.
  - Affected state: s1, s2, stable, debounce counters, pending, overflow, RR pointer.
  - Outputs: evt_valid=0, evt_id=0, pending=0, overflow=0.
  - FSM goes to IDLE.
  - Mid-handshake reset drops evt_valid without waiting for evt_ready.
- Per channel i:
  - Two-flop synchroniser s1<=raw[i], s2<=s1.
  - Counter cnt_i: at each edge where s2!=stable, cnt_i increments. At the DEBOUNCE_CYCLES-th consecutive such edge, stable<=s2 and cnt_i<=0.
  - Any edge where s2==stable clears cnt_i, so glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1 and never wraps.
- Press detection: on the edge where stable goes 0->1, pending[i]<=1. A falling stable level produces no event.
- Overflow: press detected while pending[i] is already 1 sets overflow[i]; the press is discarded.
  - clr_overflow=1 clears all overflow bits.
  - A new overflow in the same cycle as clr_overflow wins (bit stays 1).
- FSM:
  - IDLE: evt_valid=0. If any pending bit is set, grant the first set bit searching from ptr upward, wrapping N-1 -> 0.
    - On the grant edge: evt_id<=granted index, pending[granted]<=0, go PRESENT.
  - PRESENT: evt_valid=1. evt_id and evt_valid are held stable until evt_ready=1 at a clock edge.
    - On that edge: go IDLE, ptr<=(evt_id+1) mod N.
  - Throughput is at most one event per 2 clocks. evt_ready while in IDLE is ignored.
- Simultaneous events:
  - A new press on the granted channel in the same edge as its grant leaves pending=1 with no overflow; it is served later.
  - Presses on other channels during PRESENT only set their pending flags.
- Latency: raw[i] rising and held before edge 0 gives stable=1 and pending[i]=1 after edge DEBOUNCE_CYCLES+1. From IDLE with no contention, evt_valid=1 after edge DEBOUNCE_CYCLES+2.
- Fairness: a channel waits at most N-1 grants once pending.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: raw[2] 0->1 held, evt_ready=1 -> pending[2]=1 after edge 5, evt_valid=1/evt_id=2 after edge 6, accepted at edge 7, evt_valid=0 after edge 7.
- Glitch: raw[0] high for 3 clocks then low -> stable never rises, pending=0, no event. Same pulse held 4+ clocks -> one event, id 0.
- Round-robin: pending=4'b1111 simultaneously, evt_ready held 1 -> evt_id sequence 0,1,2,3, one event every 2 clocks. Then pending=4'b1001 with ptr=0 -> ids 0 then 3.
- Backpressure: evt_ready=0 for 10 clocks while in PRESENT with id 1 -> evt_valid and evt_id=1 constant. A second debounced press on ch1 during the stall -> pending[1] stays 1, overflow[1]=0. A third press -> overflow[1]=1; clr_overflow pulse -> 0.
- Async reset asserted mid-PRESENT between clock edges -> evt_valid, pending and overflow read 0 before the next posedge. After release, first grant starts from channel 0.
- Grant/press collision: new debounced press on ch3 lands on the edge ch3 is granted -> ch3 presented, pending[3]=1 after grant, ch3 served again later with no overflow.
